// File: rtl/regs_seq_pkg.sv
// regs_seq_pkg: opcodes and FSM state encoding shared by the regs_alu_seq sequencer and its ALU.
`default_nettype none

package regs_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regs_seq_alu.sv
// regs_seq_alu: combinational M-bit ALU. Carry output exists only when REGS_SEQ_FLAGS_EN is defined.
`default_nettype none

module regs_seq_alu
  import regs_seq_pkg::*;
#(
  parameter int M = 32
) (
  input  op_e          op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
`ifdef REGS_SEQ_FLAGS_EN
  output logic         carry,
`endif
  output logic [M-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = {a[M-2:0], 1'b0};
      OP_SRL:  result = {1'b0, a[M-1:1]};
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

`ifdef REGS_SEQ_FLAGS_EN
  logic [M:0] sum_wide;
  assign sum_wide = {1'b0, a} + {1'b0, b};

  // SUB reports borrow; shifts report the bit shifted out.
  always_comb begin
    carry = 1'b0;
    case (op)
      OP_ADD:  carry = sum_wide[M];
      OP_SUB:  carry = (a < b);
      OP_SLL:  carry = a[M-1];
      OP_SRL:  carry = a[0];
      default: carry = 1'b0;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: rtl/regs_alu_seq.sv
// regs_alu_seq: sequences one ALU op through a 2R/1W registered regfile (read, execute, write back).
// Optional REGS_SEQ_FLAGS_EN adds registered o_zero / o_carry outputs.
`default_nettype none

module regs_alu_seq
  import regs_seq_pkg::*;
#(
  parameter int N          = 32,
  parameter int M          = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rsn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_op,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic [ADDR_WIDTH-1:0] i_rs0,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  output logic [ADDR_WIDTH-1:0] o_reg0,
  output logic [ADDR_WIDTH-1:0] o_reg1,
  input  logic [M-1:0]          i_data0,
  input  logic [M-1:0]          i_data1,
  output logic [ADDR_WIDTH-1:0] o_reg2,
  output logic [M-1:0]          o_data2,
  output logic                  o_done,
`ifdef REGS_SEQ_FLAGS_EN
  output logic                  o_zero,
  output logic                  o_carry,
`endif
  output logic [M-1:0]          o_result
);

  state_e                state, state_next;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  accept;
  logic [M-1:0]          alu_result;
`ifdef REGS_SEQ_FLAGS_EN
  logic                  alu_carry;
`endif

  assign o_ready = (state == ST_IDLE) || (state == ST_WB);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = accept ? ST_RD : ST_IDLE;
      ST_RD:   state_next = ST_EX;
      ST_EX:   state_next = ST_WB;
      ST_WB:   state_next = accept ? ST_RD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  regs_seq_alu #(
    .M(M)
  ) u_alu (
    .op     (op_q),
    .a      (i_data0),
    .b      (i_data1),
`ifdef REGS_SEQ_FLAGS_EN
    .carry  (alu_carry),
`endif
    .result (alu_result)
  );

  // Write address is nonzero only during WB, so an abandoned op never writes.
  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      op_q     <= OP_ADD;
      rd_q     <= '0;
      o_reg0   <= '0;
      o_reg1   <= '0;
      o_reg2   <= '0;
      o_data2  <= '0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      o_reg2 <= '0;
      o_done <= 1'b0;
      if (accept) begin
        op_q   <= op_e'(i_op);
        rd_q   <= i_rd;
        o_reg0 <= i_rs0;
        o_reg1 <= i_rs1;
      end
      if (state == ST_EX) begin
        o_reg2   <= rd_q;
        o_data2  <= alu_result;
        o_result <= alu_result;
        o_done   <= 1'b1;
      end
    end
  end

`ifdef REGS_SEQ_FLAGS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      o_zero  <= 1'b0;
      o_carry <= 1'b0;
    end else if (state == ST_EX) begin
      o_zero  <= (alu_result == '0);
      o_carry <= alu_carry;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regs_alu_seq.sv
// tb_regs_alu_seq: regs_alu_seq driving a behavioural registered regfile, checked against an array model.
`default_nettype none

module tb_regs_alu_seq;

  localparam int N  = 32;
  localparam int M  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rsn;
  logic          valid;
  logic          ready;
  logic [2:0]    op;
  logic [AW-1:0] rd, rs0, rs1;
  logic [AW-1:0] reg0, reg1, reg2;
  logic [M-1:0]  data0, data1, data2, result;
  logic          done;
`ifdef REGS_SEQ_FLAGS_EN
  logic          zero, carry;
`endif

  logic          seed_we;
  logic [AW-1:0] seed_addr;
  logic [M-1:0]  seed_data;

  logic [M-1:0]  rf    [0:31];
  logic [M-1:0]  model [0:31];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regs_alu_seq #(.N(N), .M(M), .ADDR_WIDTH(AW)) dut (
    .i_clk    (clk),
    .i_rsn    (rsn),
    .i_valid  (valid),
    .o_ready  (ready),
    .i_op     (op),
    .i_rd     (rd),
    .i_rs0    (rs0),
    .i_rs1    (rs1),
    .o_reg0   (reg0),
    .o_reg1   (reg1),
    .i_data0  (data0),
    .i_data1  (data1),
    .o_reg2   (reg2),
    .o_data2  (data2),
    .o_done   (done),
`ifdef REGS_SEQ_FLAGS_EN
    .o_zero   (zero),
    .o_carry  (carry),
`endif
    .o_result (result)
  );

  // Register file: registered reads, r0 reads as zero, write on any nonzero address.
  always @(posedge clk) begin
    data0 <= (reg0 == 0) ? '0 : rf[reg0];
    data1 <= (reg1 == 0) ? '0 : rf[reg1];
    if (seed_we) rf[seed_addr] <= seed_data;
    else if (reg2 != 0) rf[reg2] <= data2;
  end

  task automatic check_val(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {flag, result}: flag is carry/borrow/shifted-out bit.
  function automatic logic [M:0] ref_alu(input logic [2:0] o, input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0] r;
    case (o)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {(a < b), a - b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {a[M-1], a << 1};
      3'd6: r = {a[0], a >> 1};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  function automatic logic [M-1:0] src(input logic [AW-1:0] a);
    return (a == 0) ? '0 : model[a];
  endfunction

  task automatic check_wb(input logic [AW-1:0] d, input logic [M:0] e);
    check_val("done", done, 1'b1);
    check_val("wb_addr", reg2, d);
    check_val("wb_data", data2, e[M-1:0]);
    check_val("result", result, e[M-1:0]);
`ifdef REGS_SEQ_FLAGS_EN
    check_val("zero", zero, (e[M-1:0] == 0));
    check_val("carry", carry, e[M]);
`endif
  endtask

  task automatic run_op(input logic [2:0] o, input logic [AW-1:0] d, input logic [AW-1:0] s0,
                        input logic [AW-1:0] s1, output logic [M-1:0] res);
    logic [M:0] e;
    int cyc;
    e = ref_alu(o, src(s0), src(s1));
    @(negedge clk);
    check_val("ready_idle", ready, 1'b1);
    check_val("done_pulse", done, 1'b0);
    valid = 1'b1; op = o; rd = d; rs0 = s0; rs1 = s1;
    @(negedge clk);
    valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 8) begin
      check_val("busy_ready", ready, 1'b0);
      check_val("busy_wraddr", reg2, '0);
      @(negedge clk);
      cyc++;
    end
    check_val("latency", cyc, 3);
    check_wb(d, e);
    if (d != 0) model[d] = e[M-1:0];
    res = result;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [M-1:0] res;
    logic [M:0]   e1, e2;
    int           diffs;

    rsn = 1'b0; valid = 1'b0; op = '0; rd = '0; rs0 = '0; rs1 = '0;
    seed_we = 1'b0; seed_addr = '0; seed_data = '0;
    model[0] = '0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      seed_we   = 1'b1;
      seed_addr = AW'(i);
      seed_data = (i == 10) ? 32'd5 : (i == 11) ? 32'd3 : $urandom;
      model[i]  = seed_data;
    end
    @(negedge clk);
    seed_we = 1'b0;
    check_val("rst_ready", ready, 1'b1);
    check_val("rst_wraddr", reg2, '0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_result", result, '0);
`ifdef REGS_SEQ_FLAGS_EN
    check_val("rst_zero", zero, 1'b0);
    check_val("rst_carry", carry, 1'b0);
`endif
    rsn = 1'b1;

    // Preload r1=5, r2=3 and add them.
    run_op(3'd7, 5'd1, 5'd10, 5'd0, res);
    run_op(3'd7, 5'd2, 5'd11, 5'd0, res);
    run_op(3'd0, 5'd3, 5'd1, 5'd2, res);
    check_val("add_result", res, 32'd8);
    @(negedge clk);
    check_val("rf_r3", rf[3], 32'd8);

    // Back-to-back: second op accepted in WB of the first must see its write.
    e1 = ref_alu(3'd0, src(5'd1), src(5'd2));
    valid = 1'b1; op = 3'd0; rd = 5'd4; rs0 = 5'd1; rs1 = 5'd2;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_wb(5'd4, e1);
    check_val("b2b_ready_wb", ready, 1'b1);
    model[4] = e1[M-1:0];
    e2 = ref_alu(3'd1, src(5'd4), src(5'd1));
    valid = 1'b1; op = 3'd1; rd = 5'd5; rs0 = 5'd4; rs1 = 5'd1;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_wb(5'd5, e2);
    check_val("b2b_result", result, 32'd3);
    model[5] = e2[M-1:0];
    @(negedge clk);
    check_val("rf_r5", rf[5], 32'd3);

    run_op(3'd1, 5'd6, 5'd2, 5'd1, res);
    check_val("sub_result", res, 32'hFFFF_FFFE);
`ifdef REGS_SEQ_FLAGS_EN
    check_val("sub_borrow", carry, 1'b1);
`endif
    run_op(3'd4, 5'd7, 5'd1, 5'd1, res);
    check_val("xor_result", res, '0);
`ifdef REGS_SEQ_FLAGS_EN
    check_val("xor_zero", zero, 1'b1);
`endif
    run_op(3'd0, 5'd0, 5'd1, 5'd2, res);
    check_val("rd0_result", res, 32'd8);

    // Reset while in EX: the op is abandoned and r9 keeps its value.
    @(negedge clk);
    valid = 1'b1; op = 3'd0; rd = 5'd9; rs0 = 5'd1; rs1 = 5'd2;
    @(negedge clk); valid = 1'b0;
    @(negedge clk); rsn = 1'b0;
    @(negedge clk);
    check_val("rstex_wraddr", reg2, '0);
    check_val("rstex_done", done, 1'b0);
    check_val("rstex_ready", ready, 1'b1);
    check_val("rstex_result", result, '0);
    rsn = 1'b1;
    @(negedge clk);
    check_val("rstex_r9", rf[9], model[9]);

    for (int k = 0; k < 30; k++) begin
      run_op(3'($urandom_range(0, 7)), AW'($urandom_range(0, 31)),
             AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), res);
    end

    @(negedge clk);
    diffs = 0;
    for (int i = 1; i < 32; i++) if (rf[i] !== model[i]) diffs++;
    check_val("rf_final_diffs", diffs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
